data_mem_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the single-port data memory.

---
 rtl/data_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-port data memory between
// two masters: one ACCESS cycle per grant, then a one-cycle registered ack in RESP.
module data_mem_arbiter #(
  parameter int MEM_AW = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_ack,
  output logic             m0_err,
  output logic [31:0]      m0_rdata,

  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_ack,
  output logic             m1_err,
  output logic [31:0]      m1_rdata,

  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,

  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic        grant_id;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        arb_slot;
  logic        elig0;
  logic        elig1;
  logic        tie;
  logic        win_valid;
  logic        win_id;
  logic        in_range;
  logic [31:0] access_rdata;

  // The port being acked in RESP still holds its request, so it is masked out.
  always_comb begin
    arb_slot     = (state == IDLE) || (state == RESP);
    elig0        = arb_slot && m0_req && !(state == RESP && grant_id == 1'b0);
    elig1        = arb_slot && m1_req && !(state == RESP && grant_id == 1'b1);
    tie          = elig0 && elig1;
    win_valid    = elig0 || elig1;
    win_id       = tie ? ~last_grant : elig1;
    in_range     = (lat_addr >> MEM_AW) == 32'd0;
    access_rdata = (in_range && !lat_we) ? mem_rdata : 32'd0;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (state == ACCESS) begin
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      mem_read  = in_range && !lat_we;
      // A write caught by reset in its ACCESS cycle must never reach the memory.
      mem_write = in_range && lat_we && !reset;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      conflict_cnt <= '0;
      m0_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m0_rdata     <= 32'd0;
      m1_ack       <= 1'b0;
      m1_err       <= 1'b0;
      m1_rdata     <= 32'd0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (win_valid) begin
            grant_id   <= win_id;
            last_grant <= win_id;
            lat_we     <= win_id ? m1_we    : m0_we;
            lat_addr   <= win_id ? m1_addr  : m0_addr;
            lat_wdata  <= win_id ? m1_wdata : m0_wdata;
            if (tie && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
            state <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (grant_id == 1'b0) begin
            m0_ack   <= 1'b1;
            m0_err   <= !in_range;
            m0_rdata <= access_rdata;
          end else begin
            m1_ack   <= 1'b1;
            m1_err   <= !in_range;
            m1_rdata <= access_rdata;
          end
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios, then random two-master traffic
// scored against a transaction-level shadow memory.
module tb_data_mem_arbiter;

  localparam int MEM_AW   = 8;
  localparam int CNT_W    = 3;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic reset;
  logic m0_req, m0_we, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic m1_req, m1_we, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [CNT_W-1:0] conflict_cnt;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MEM_AW(MEM_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Environment memory: combinational read, write on the clock edge.
  logic [31:0] mem_arr [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_addr] <= pl_data;
    else if (mem_write) mem_arr[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = mem_arr[mem_addr[7:0]];

  // Reference model state: expected memory contents and per-port outstanding request.
  logic [31:0] shadow [256];
  logic        pend [2];
  logic        p_we [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  int          age [2];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'hDEAD_BEEF;
    if (i >= 32 && i < 48) return 32'hC0DE_0000 | 32'(i);
    return 32'd0;
  endfunction

  function automatic logic ack_of(input int p);
    return (p == 0) ? m0_ack : m1_ack;
  endfunction

  function automatic logic err_of(input int p);
    return (p == 0) ? m0_err : m1_err;
  endfunction

  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? m0_rdata : m1_rdata;
  endfunction

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic apply_drive();
    for (int p = 0; p < 2; p++) drive(p, pend[p], p_we[p], p_addr[p], p_wdata[p]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m0_ack"},   m0_ack,   0);
    check({tag, "_m0_err"},   m0_err,   0);
    check({tag, "_m0_rdata"}, m0_rdata, 0);
    check({tag, "_m1_ack"},   m1_ack,   0);
    check({tag, "_m1_err"},   m1_err,   0);
    check({tag, "_m1_rdata"}, m1_rdata, 0);
    check({tag, "_mem_read"}, mem_read, 0);
    check({tag, "_mem_write"}, mem_write, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_conflict_cnt"}, conflict_cnt, 0);
  endtask

  task automatic wait_ack(input int p, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!ack_of(p) && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ack"}, ack_of(p), 1'b1);
  endtask

  // A finished access: out of range -> error and no effect; read returns the current
  // memory contents; write returns 0 and updates memory.
  task automatic complete(input int p, input string tag);
    logic        oor;
    logic [7:0]  idx;
    logic [31:0] exp_rdata;
    idx       = p_addr[p][7:0];
    oor       = (p_addr[p] >> MEM_AW) != 32'd0;
    exp_rdata = (oor || p_we[p]) ? 32'd0 : shadow[idx];
    check($sformatf("%s_m%0d_err", tag, p), err_of(p), oor);
    check($sformatf("%s_m%0d_rdata", tag, p), rdata_of(p), exp_rdata);
    if (!oor && p_we[p]) shadow[idx] = p_wdata[p];
    pend[p] = 1'b0;
  endtask

  task automatic serve_cycle(input string tag);
    check($sformatf("%s_ack_excl", tag), m0_ack && m1_ack, 1'b0);
    for (int p = 0; p < 2; p++) begin
      if (ack_of(p)) begin
        if (pend[p]) complete(p, tag);
        else check($sformatf("%s_m%0d_spurious_ack", tag, p), ack_of(p), 1'b0);
      end else if (pend[p]) begin
        age[p]++;
        if (age[p] > MAX_WAIT) begin
          check($sformatf("%s_m%0d_ack_timeout", tag, p), ack_of(p), 1'b1);
          pend[p] = 1'b0;
        end
      end
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    pend[p] = 1'b1; age[p] = 0; p_we[p] = we; p_addr[p] = addr; p_wdata[p] = wdata;
  endtask

  task automatic issue_random(input int p);
    logic [31:0] addr;
    if ($urandom_range(0, 7) == 0)
      addr = (32'd1 << $urandom_range(MEM_AW, 31)) | 32'($urandom_range(0, 15));
    else
      addr = 32'($urandom_range(0, 15));
    issue(p, 1'($urandom_range(0, 1)), addr, $urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    pl_en = 1'b0; pl_addr = 8'd0; pl_data = 32'd0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = 32'd0; p_wdata[p] = 32'd0; age[p] = 0;
    end

    // Preload memory while reset is held.
    for (int i = 0; i < 256; i++) begin
      shadow[i] = init_val(i);
      pl_en = 1'b1; pl_addr = 8'(i); pl_data = init_val(i);
      @(negedge clk);
    end
    pl_en = 1'b0;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Single read: ACCESS one cycle after the request, ack one cycle later.
    drive(0, 1'b1, 1'b0, 32'd5, 32'd0);
    @(negedge clk);
    check("rd_mem_read", mem_read, 1'b1);
    check("rd_mem_addr", mem_addr, 32'd5);
    check("rd_early_ack", m0_ack, 1'b0);
    @(negedge clk);
    check("rd_ack", m0_ack, 1'b1);
    check("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("rd_err", m0_err, 1'b0);
    check("rd_m1_ack", m1_ack, 1'b0);
    check("rd_mem_read_after", mem_read, 1'b0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("rd_ack_pulse", m0_ack, 1'b0);
    check("rd_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

    // Write then read on port 1; the read is presented while the write is acked.
    drive(1, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
    @(negedge clk);
    check("wr_mem_write", mem_write, 1'b1);
    check("wr_mem_read", mem_read, 1'b0);
    check("wr_mem_addr", mem_addr, 32'h10);
    check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    check("wr_ack", m1_ack, 1'b1);
    check("wr_rdata", m1_rdata, 32'd0);
    check("wr_err", m1_err, 1'b0);
    check("wr_mem_content", mem_arr[16], 32'h1234_5678);
    shadow[16] = 32'h1234_5678;
    drive(1, 1'b1, 1'b0, 32'h10, 32'd0);
    wait_ack(1, "rd10");
    check("rd10_rdata", m1_rdata, 32'h1234_5678);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Out-of-range write: never reaches memory, error ack still given.
    drive(0, 1'b1, 1'b1, 32'h100, 32'hCAFE_F00D);
    @(negedge clk);
    check("oor_mem_write", mem_write, 1'b0);
    check("oor_mem_read", mem_read, 1'b0);
    @(negedge clk);
    check("oor_ack", m0_ack, 1'b1);
    check("oor_err", m0_err, 1'b1);
    check("oor_rdata", m0_rdata, 32'd0);
    drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
    wait_ack(0, "oor_rb");
    check("oor_rb_rdata", m0_rdata, 32'd0);
    check("oor_rb_err", m0_err, 1'b0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Reset during the ACCESS cycle of a write: write suppressed, no ack.
    drive(0, 1'b1, 1'b1, 32'd3, 32'hAAAA_5555);
    @(negedge clk);
    check("rst_mid_mem_write", mem_write, 1'b1);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("rst_mid_gate", mem_write, 1'b0);
    @(negedge clk);
    check_idle_outputs("rst_mid");
    check("rst_mid_mem3", mem_arr[3], 32'd0);
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'd3, 32'd0);
    wait_ack(0, "rst_rb");
    check("rst_rb_rdata", m0_rdata, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Contention from reset: slot s reads address 0x20+s; grants alternate m0,m1,m0,m1.
    // Only the first arbitration is a tie; later ones see the acked port masked.
    do_reset();
    drive(0, 1'b1, 1'b0, 32'h20, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h21, 32'd0);
    for (int s = 0; s < 4; s++) begin
      int p;
      p = s % 2;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("slot%0d_ack_m%0d", s, p), ack_of(p), 1'b1);
      check($sformatf("slot%0d_noack_m%0d", s, 1 - p), ack_of(1 - p), 1'b0);
      check($sformatf("slot%0d_rdata", s), rdata_of(p), init_val(32 + s));
      if (s < 2) drive(p, 1'b1, 1'b0, 32'(34 + s), 32'd0);
      else drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    check("cont_cnt", conflict_cnt, 1);
    @(negedge clk);

    // Saturation: one tie per round from IDLE, counter sticks at all-ones.
    do_reset();
    for (int k = 1; k <= (1 << CNT_W) + 3; k++) begin
      int n;
      int exp_cnt;
      @(negedge clk);
      issue(0, 1'b0, 32'($urandom_range(0, 15)), 32'd0);
      issue(1, 1'b0, 32'($urandom_range(0, 15)), 32'd0);
      apply_drive();
      n = 0;
      do begin
        @(negedge clk);
        serve_cycle("sat");
        apply_drive();
        n++;
      end while ((pend[0] || pend[1]) && n < 2 * MAX_WAIT);
      exp_cnt = (k < (1 << CNT_W) - 1) ? k : (1 << CNT_W) - 1;
      check($sformatf("sat_cnt_round%0d", k), conflict_cnt, exp_cnt);
    end

    // Random two-master traffic against the shadow memory.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      serve_cycle("rnd");
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 2) == 0) issue_random(p);
      apply_drive();
    end
    for (int c = 0; c < 2 * MAX_WAIT && (pend[0] || pend[1]); c++) begin
      @(negedge clk);
      serve_cycle("drain");
      apply_drive();
    end
    for (int i = 0; i < 16; i++)
      check($sformatf("final_mem%0d", i), mem_arr[i], shadow[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
